cnn_window_gen: RTL and testbench

//  Turns a raster-order pixel stream (one pixel per valid beat, row-major) into
//  KX x KY sliding windows, one window per valid output pixel position.

---
 rtl/cnn_window_gen_pkg.sv | 10 +
 rtl/cnn_window_gen_if.sv | 16 +
 rtl/cnn_line_buffer.sv | 19 +
 rtl/cnn_window_gen.sv | 90 +++++++++
 tb/tb_cnn_window_gen.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_window_gen_pkg.sv
// cnn_pkg: default geometry and counter widths shared by the window generator files
package cnn_pkg;
  localparam int DEF_KX = 5;
  localparam int DEF_KY = 5;
  localparam int DEF_I_F_BW = 8;
  localparam int DEF_IW = 28;
  localparam int DEF_IH = 28;
  localparam int CW = $clog2(DEF_IW);
  localparam int RW = $clog2(DEF_IH);
endpackage

// File: rtl/cnn_window_gen_if.sv
// cnn_window_gen_if: pixel-in / window-out stream bundle of the window generator
interface cnn_window_gen_if
  import cnn_pkg::*;
#(
  parameter int KX = DEF_KX,
  parameter int KY = DEF_KY,
  parameter int I_F_BW = DEF_I_F_BW
);
  logic i_in_valid;
  logic [I_F_BW-1:0] i_in_pixel;
  logic o_ot_valid;
  logic [KX*KY*I_F_BW-1:0] o_ot_fmap;
  logic o_frame_done;
  modport master (output i_in_valid, i_in_pixel, input o_ot_valid, o_ot_fmap, o_frame_done);
  modport slave (input i_in_valid, i_in_pixel, output o_ot_valid, o_ot_fmap, o_frame_done);
endinterface

// File: rtl/cnn_line_buffer.sv
// cnn_line_buffer: one image-row delay, read-before-write at a shared column address
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = DEF_IW,
  parameter int W = DEF_I_F_BW,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem_q [DEPTH];
  assign dout = mem_q[addr];
  always_ff @(posedge clk)
    if (we) mem_q[addr] <= din;
endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster pixel stream to KX x KY sliding windows, valid padding, stride 1
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int KX = DEF_KX,
  parameter int KY = DEF_KY,
  parameter int I_F_BW = DEF_I_F_BW,
  parameter int IW = DEF_IW,
  parameter int IH = DEF_IH
) (
  input logic clk,
  input logic reset,
  input logic i_clear,
  cnn_window_gen_if.slave bus
);
  localparam int CBW = $clog2(IW);
  localparam int RBW = $clog2(IH);
  logic [CBW-1:0] col_q, col_d;
  logic [RBW-1:0] row_q, row_d;
  logic [I_F_BW-1:0] win_q [KY][KX];
  logic [I_F_BW-1:0] win_d [KY][KX];
  logic [I_F_BW-1:0] tap [KY];
  logic [I_F_BW-1:0] lb_in [KY-1];
  logic [I_F_BW-1:0] lb_out [KY-1];
  logic [KX*KY*I_F_BW-1:0] fmap_q, fmap_d;
  logic valid_q, valid_d, done_q, done_d;
  logic beat, last_col, last_row;
  assign beat = bus.i_in_valid & ~i_clear;
  assign last_col = col_q == CBW'(IW - 1);
  assign last_row = row_q == RBW'(IH - 1);
  assign tap[KY-1] = bus.i_in_pixel;
  // delay k holds image row (row-k-1), so it feeds window row KY-2-k
  for (genvar k = 0; k < KY - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_in[k] = bus.i_in_pixel;
    end else begin : g_tail
      assign lb_in[k] = lb_out[k-1];
    end
    assign tap[KY-2-k] = lb_out[k];
    cnn_line_buffer #(.DEPTH(IW), .W(I_F_BW), .AW(CBW)) u_lb (
      .clk(clk), .we(beat), .addr(col_q), .din(lb_in[k]), .dout(lb_out[k])
    );
  end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    fmap_d = fmap_q;
    valid_d = 1'b0;
    done_d = 1'b0;
    if (beat) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      row_d = !last_col ? row_q : last_row ? '0 : row_q + 1'b1;
      for (int r = 0; r < KY; r++) begin
        for (int c = 0; c < KX - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][KX-1] = tap[r];
      end
      valid_d = col_q >= CBW'(KX - 1) && row_q >= RBW'(KY - 1);
      done_d = last_col && last_row;
    end
    for (int r = 0; r < KY; r++)
      for (int c = 0; c < KX; c++)
        if (valid_d) fmap_d[(r*KX+c)*I_F_BW +: I_F_BW] = win_d[r][c];
    if (i_clear) begin
      col_d = '0;
      row_d = '0;
      win_d = '{default: '0};
      fmap_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      fmap_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      fmap_q <= fmap_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  assign bus.o_ot_valid = valid_q;
  assign bus.o_ot_fmap = fmap_q;
  assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: directed scenarios for the 5x5/28x28 generator and a 3x3/4x3 instance
module tb_cnn_window_gen;
  localparam int W = 200;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, clr2 = 1'b0;
  int errors = 0, checks = 0;
  logic [W-1:0] obs_w[$], ref_w[$];
  int obs_pos[$], ref_pos[$], obs_done[$];
  int idle_bad, done_cnt;
  always #5 clk = ~clk;
  cnn_window_gen_if #(.KX(5), .KY(5), .I_F_BW(8)) bus ();
  cnn_window_gen_if #(.KX(3), .KY(3), .I_F_BW(8)) bus2 ();
  cnn_window_gen dut (.clk(clk), .reset(reset), .i_clear(clr), .bus(bus));
  cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(8), .IW(4), .IH(3)) dut2 (
    .clk(clk), .reset(reset), .i_clear(clr2), .bus(bus2)
  );

  function automatic logic [7:0] pix(int i, bit inv);
    logic [7:0] p;
    p = 8'(i % 256);
    return inv ? ~p : p;
  endfunction

  function automatic logic [W-1:0] exp_win(int pos, bit inv);
    logic [W-1:0] w;
    int row, col;
    w = '0;
    row = pos / 28;
    col = pos % 28;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[(r*5+c)*8 +: 8] = pix((row - 4 + r) * 28 + col - 4 + c, inv);
    return w;
  endfunction

  function automatic logic [7:0] el(logic [W-1:0] w, int r, int c);
    return w[(r*5+c)*8 +: 8];
  endfunction

  task automatic step(input logic v, input logic [7:0] p);
    bus.i_in_valid = v;
    bus.i_in_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input bit inv, input bit gaps, input int nbeats);
    int g;
    obs_w.delete();
    obs_pos.delete();
    obs_done.delete();
    idle_bad = 0;
    done_cnt = 0;
    for (int i = 0; i < nbeats; i++) begin
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int j = 0; j < g; j++) begin
        step(1'b0, 8'($urandom));
        if (bus.o_ot_valid || bus.o_frame_done) idle_bad++;
      end
      step(1'b1, pix(i, inv));
      if (bus.o_ot_valid) begin
        obs_w.push_back(bus.o_ot_fmap);
        obs_pos.push_back(i);
      end
      if (bus.o_frame_done) begin
        done_cnt++;
        obs_done.push_back(i);
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks += 5;
    if (bus.o_ot_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", bus.o_ot_valid); end
    if (bus.o_ot_fmap !== '0) begin errors++; $display("FAIL reset_fmap got=%h want=0", bus.o_ot_fmap); end
    if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", bus.o_frame_done); end
    if (bus2.o_ot_valid !== 1'b0) begin errors++; $display("FAIL reset2_valid got=%0b want=0", bus2.o_ot_valid); end
    if (bus2.o_ot_fmap !== '0) begin errors++; $display("FAIL reset2_fmap got=%h want=0", bus2.o_ot_fmap); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single_frame;
    logic [W-1:0] w0;
    int mism;
    stream(1'b0, 1'b0, 784);
    w0 = obs_w.size() > 0 ? obs_w[0] : '0;
    mism = 0;
    foreach (obs_w[k]) if (obs_w[k] !== exp_win(obs_pos[k], 1'b0)) mism++;
    checks += 9;
    if (obs_w.size() != 576) begin errors++; $display("FAIL f1_count got=%0d want=576", obs_w.size()); end
    if ((obs_pos.size() > 0 ? obs_pos[0] : -1) != 116) begin errors++; $display("FAIL f1_first_pos got=%0d want=116", obs_pos.size() > 0 ? obs_pos[0] : -1); end
    if (el(w0, 0, 0) !== 8'd0) begin errors++; $display("FAIL f1_e00 got=%0d want=0", el(w0, 0, 0)); end
    if (el(w0, 0, 4) !== 8'd4) begin errors++; $display("FAIL f1_e04 got=%0d want=4", el(w0, 0, 4)); end
    if (el(w0, 4, 0) !== 8'd112) begin errors++; $display("FAIL f1_e40 got=%0d want=112", el(w0, 4, 0)); end
    if (el(w0, 4, 4) !== 8'd116) begin errors++; $display("FAIL f1_e44 got=%0d want=116", el(w0, 4, 4)); end
    if (mism != 0) begin errors++; $display("FAIL f1_windows mismatching=%0d want=0", mism); end
    if (done_cnt != 1 || (obs_done.size() > 0 ? obs_done[0] : -1) != 783) begin
      errors++; $display("FAIL f1_done count=%0d want=1 at=%0d want=783", done_cnt, obs_done.size() > 0 ? obs_done[0] : -1);
    end
    ref_w = obs_w;
    ref_pos = obs_pos;
    step(1'b0, 8'h5A);
    if (bus.o_ot_valid !== 1'b0 || bus.o_ot_fmap !== exp_win(783, 1'b0)) begin
      errors++; $display("FAIL f1_idle_hold valid=%0b fmap=%h want valid=0 fmap=%h", bus.o_ot_valid, bus.o_ot_fmap, exp_win(783, 1'b0));
    end
  endtask

  task automatic test_gaps;
    int mism;
    stream(1'b0, 1'b1, 784);
    mism = 0;
    foreach (obs_w[k]) if (k >= ref_w.size() || obs_w[k] !== ref_w[k] || obs_pos[k] != ref_pos[k]) mism++;
    checks += 4;
    if (obs_w.size() != 576) begin errors++; $display("FAIL gaps_count got=%0d want=576", obs_w.size()); end
    if (mism != 0) begin errors++; $display("FAIL gaps_windows mismatching=%0d want=0", mism); end
    if (idle_bad != 0) begin errors++; $display("FAIL gaps_idle_valid got=%0d want=0", idle_bad); end
    if (done_cnt != 1) begin errors++; $display("FAIL gaps_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_row_wrap;
    int a, b, between;
    a = -1;
    b = -1;
    between = 0;
    foreach (ref_pos[k]) begin
      if (ref_pos[k] == 167) a = k;
      if (ref_pos[k] == 172) b = k;
      if (ref_pos[k] >= 168 && ref_pos[k] <= 171) between++;
    end
    checks += 6;
    if (a < 0 || el(ref_w[a], 4, 4) !== 8'd167) begin errors++; $display("FAIL wrap_527_e44 idx=%0d want=167", a); end
    if (a < 0 || el(ref_w[a], 0, 0) !== 8'd51) begin errors++; $display("FAIL wrap_527_e00 idx=%0d want=51", a); end
    if (b < 0 || el(ref_w[b], 4, 4) !== 8'd172) begin errors++; $display("FAIL wrap_64_e44 idx=%0d want=172", b); end
    if (b < 0 || el(ref_w[b], 4, 0) !== 8'd168) begin errors++; $display("FAIL wrap_64_e40 idx=%0d want=168", b); end
    if (between != 0) begin errors++; $display("FAIL wrap_gap_valid got=%0d want=0", between); end
    if (b != a + 1) begin errors++; $display("FAIL wrap_adjacent got=%0d want=%0d", b, a + 1); end
  endtask

  task automatic test_back_to_back;
    int mism;
    for (int f = 0; f < 2; f++) begin
      stream(f[0], 1'b0, 784);
      mism = 0;
      foreach (obs_w[k]) if (obs_w[k] !== exp_win(obs_pos[k], f[0])) mism++;
      checks += 3;
      if (obs_w.size() != 576 || (obs_pos.size() > 0 ? obs_pos[obs_pos.size()-1] : -1) != 783) begin
        errors++; $display("FAIL b2b_count frame=%0d got=%0d want=576", f, obs_w.size());
      end
      if (done_cnt != 1 || (obs_done.size() > 0 ? obs_done[0] : -1) != 783) begin
        errors++; $display("FAIL b2b_done frame=%0d count=%0d want=1", f, done_cnt);
      end
      if (mism != 0) begin errors++; $display("FAIL b2b_windows frame=%0d mismatching=%0d want=0", f, mism); end
    end
  endtask

  task automatic test_restart(input bit use_reset);
    int mism;
    stream(1'b0, 1'b0, 300);
    checks += 4;
    if (bus.o_ot_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got=%0b want=1", bus.o_ot_valid); end
    if (use_reset) begin
      reset = 1'b1;
      #2;
    end else begin
      clr = 1'b1;
      step(1'b1, 8'hAA);
      clr = 1'b0;
    end
    if (bus.o_ot_valid !== 1'b0 || bus.o_frame_done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl rst=%0b valid=%0b done=%0b want 0 0", use_reset, bus.o_ot_valid, bus.o_frame_done);
    end
    if (bus.o_ot_fmap !== '0) begin errors++; $display("FAIL abort_fmap rst=%0b got=%h want=0", use_reset, bus.o_ot_fmap); end
    if (use_reset) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
    stream(1'b0, 1'b0, 784);
    mism = 0;
    foreach (obs_w[k]) if (k >= ref_w.size() || obs_w[k] !== ref_w[k] || obs_pos[k] != ref_pos[k]) mism++;
    if (obs_w.size() != 576 || mism != 0) begin
      errors++; $display("FAIL abort_restart rst=%0b count=%0d mismatching=%0d want 576 0", use_reset, obs_w.size(), mism);
    end
  endtask

  task automatic test_small;
    logic [71:0] e0, e1, got[$];
    int pos[$], dn[$];
    e0 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    e1 = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
    for (int i = 0; i < 12; i++) begin
      bus2.i_in_valid = 1'b1;
      bus2.i_in_pixel = 8'(i);
      @(posedge clk);
      #1;
      if (bus2.o_ot_valid) begin got.push_back(bus2.o_ot_fmap); pos.push_back(i); end
      if (bus2.o_frame_done) dn.push_back(i);
    end
    bus2.i_in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks += 6;
    if (got.size() != 2) begin errors++; $display("FAIL small_count got=%0d want=2", got.size()); end
    if ((pos.size() > 0 ? pos[0] : -1) != 10) begin errors++; $display("FAIL small_first_pos got=%0d want=10", pos.size() > 0 ? pos[0] : -1); end
    if ((got.size() > 0 ? got[0] : '0) !== e0) begin errors++; $display("FAIL small_win0 got=%h want=%h", got.size() > 0 ? got[0] : '0, e0); end
    if ((got.size() > 1 ? got[1] : '0) !== e1) begin errors++; $display("FAIL small_win1 got=%h want=%h", got.size() > 1 ? got[1] : '0, e1); end
    if (dn.size() != 1 || (dn.size() > 0 ? dn[0] : -1) != 11) begin errors++; $display("FAIL small_done count=%0d want=1 at 11", dn.size()); end
    if (bus2.o_ot_valid !== 1'b0 || bus2.o_ot_fmap !== e1) begin
      errors++; $display("FAIL small_idle_hold valid=%0b fmap=%h want 0 %h", bus2.o_ot_valid, bus2.o_ot_fmap, e1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_in_valid = 1'b0;
    bus.i_in_pixel = '0;
    bus2.i_in_valid = 1'b0;
    bus2.i_in_pixel = '0;
    test_reset();
    test_single_frame();
    test_gaps();
    test_row_wrap();
    test_back_to_back();
    test_restart(1'b0);
    test_restart(1'b1);
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
